// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one-hot column strobe, row sampling, press and
// release debounce, and a valid/ack key handshake with sticky overrun.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SCAN     = 2'd1;
  localparam logic [1:0] ST_DEBOUNCE = 2'd2;
  localparam logic [1:0] ST_PRESSED  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       col;
  logic [1:0]       row;
  logic [DIV_W-1:0] div;
  logic [DB_W-1:0]  db;

  logic             row_onehot;
  logic [1:0]       row_idx;
  logic             row_match;
  logic             load;

  // Row decode: a sample only counts as a key when exactly one row is high.
  always_comb begin
    row_onehot = 1'b0;
    row_idx    = 2'd0;
    case (filas)
      4'b0001: begin row_onehot = 1'b1; row_idx = 2'd0; end
      4'b0010: begin row_onehot = 1'b1; row_idx = 2'd1; end
      4'b0100: begin row_onehot = 1'b1; row_idx = 2'd2; end
      4'b1000: begin row_onehot = 1'b1; row_idx = 2'd3; end
      default: begin row_onehot = 1'b0; row_idx = 2'd0; end
    endcase
  end

  // Column drive, held indication, and the press-accept strobe.
  always_comb begin
    row_match = (filas == (4'b0001 << row));
    columnas  = (state == ST_IDLE) ? 4'b0000 : (4'b0001 << col);
    key_held  = (state == ST_PRESSED);
    load      = enable && (state == ST_DEBOUNCE) && row_match && (db == DB_LAST);
  end

  // Scan sequencer: walk columns, freeze on a candidate, debounce press and release.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      state <= ST_IDLE;
      col   <= 2'd0;
      row   <= 2'd0;
      div   <= '0;
      db    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_SCAN;
          col   <= 2'd0;
          div   <= '0;
        end
        ST_SCAN: begin
          if (div == DIV_LAST) begin
            div <= '0;
            if (row_onehot) begin
              row   <= row_idx;
              db    <= '0;
              state <= ST_DEBOUNCE;
            end else begin
              col <= col + 2'd1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_match) begin
            state <= ST_SCAN;
            div   <= '0;
            db    <= '0;
          end else if (db == DB_LAST) begin
            state <= ST_PRESSED;
            db    <= '0;
          end else begin
            db <= db + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (row_match) begin
            db <= '0;
          end else if (db == DB_LAST) begin
            state <= ST_SCAN;
            col   <= col + 2'd1;
            div   <= '0;
            db    <= '0;
          end else begin
            db <= db + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Key handshake: a load beats a same-cycle ack; a blocked load flags overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load && (!key_valid || key_ack)) begin
      key_code  <= {col, row};
      key_valid <= 1'b1;
    end else begin
      if (load) begin
        overrun <= 1'b1;
      end
      if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CNT=3: vector table,
// directed corner sequences, and random stimulus against a behavioural model.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] filas = 4'd0;
  logic       key_ack = 1'b0;
  logic [3:0] columnas;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .filas(filas),
    .columnas(columnas), .key_code(key_code), .key_valid(key_valid),
    .key_ack(key_ack), .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase names, a cycle timer and a key mailbox.
  localparam int PH_OFF = 0, PH_WALK = 1, PH_CONFIRM = 2, PH_DOWN = 3;
  int m_phase = PH_OFF;
  int m_col = 0;
  int m_row = 0;
  int m_timer = 0;
  int m_code = 0;
  bit m_vld = 0;
  bit m_ovr = 0;

  function automatic int exp_cols();
    if (m_phase == PH_OFF) return 0;
    return 1 << m_col;
  endfunction

  task automatic model_step();
    bit was_vld;
    bit accept;
    int f;
    f = int'(filas);
    accept = 0;
    was_vld = m_vld;
    if (!reset) begin
      m_phase = PH_OFF; m_col = 0; m_row = 0; m_timer = 0;
      m_code = 0; m_vld = 0; m_ovr = 0;
      return;
    end
    if (!enable) begin
      m_phase = PH_OFF; m_col = 0; m_timer = 0;
      if (m_vld && key_ack) m_vld = 0;
      return;
    end
    if (m_phase == PH_OFF) begin
      m_phase = PH_WALK; m_col = 0; m_timer = 0;
    end else if (m_phase == PH_WALK) begin
      if (m_timer < SD - 1) m_timer++;
      else begin
        m_timer = 0;
        if ($countones(filas) == 1) begin
          for (int i = 0; i < 4; i++) if (f == (1 << i)) m_row = i;
          m_phase = PH_CONFIRM;
        end else m_col = (m_col + 1) % 4;
      end
    end else if (m_phase == PH_CONFIRM) begin
      if (f != (1 << m_row)) begin
        m_phase = PH_WALK; m_timer = 0;
      end else if (m_timer + 1 == DC) begin
        m_phase = PH_DOWN; m_timer = 0; accept = 1;
      end else m_timer++;
    end else begin
      if (f == (1 << m_row)) m_timer = 0;
      else if (m_timer + 1 == DC) begin
        m_phase = PH_WALK; m_col = (m_col + 1) % 4; m_timer = 0;
      end else m_timer++;
    end
    if (was_vld && key_ack) m_vld = 0;
    if (accept) begin
      if (!was_vld || key_ack) begin
        m_code = m_col * 4 + m_row; m_vld = 1;
      end else m_ovr = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model_columnas", 32'(columnas), 32'(exp_cols()));
    chk("model_key_code", 32'(key_code), 32'(m_code));
    chk("model_key_valid", 32'(key_valid), 32'(m_vld));
    chk("model_key_held", 32'(key_held), 32'(m_phase == PH_DOWN));
    chk("model_overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b1; filas = 4'd0; key_ack = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic wait_col(input logic [3:0] c);
    int n;
    n = 0;
    while (columnas !== c && n < 40) begin
      cycle();
      n++;
    end
    chk("wait_column", 32'(columnas), 32'(c));
  endtask

  task automatic press_release(input int c, input int r);
    wait_col(4'(1 << c));
    filas = 4'(1 << r);
    repeat (10) cycle();
    filas = 4'd0;
    repeat (4) cycle();
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] f;
    logic       ack;
    logic [3:0] ecol;
    logic       evld;
    logic       eovr;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // Reset edge, then the free-running walk, then a two-row chord on column 0.
    tbl[0] = '{1'b0, 1'b1, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    for (int i = 1; i <= 17; i++)
      tbl[i] = '{1'b1, 1'b1, 4'd0, 1'b0, 4'(1 << (((i - 1) / 4) % 4)), 1'b0, 1'b0};
    for (int i = 18; i <= 20; i++)
      tbl[i] = '{1'b1, 1'b1, 4'b0011, 1'b0, 4'b0001, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0};

    for (int i = 0; i < 23; i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; filas = tbl[i].f; key_ack = tbl[i].ack;
      cycle();
      chk($sformatf("tbl%0d_columnas", i), 32'(columnas), 32'(tbl[i].ecol));
      chk($sformatf("tbl%0d_key_valid", i), 32'(key_valid), 32'(tbl[i].evld));
      chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].eovr));
    end

    // Press on column 2 row 1: latency, ack, release and resume on column 3.
    do_reset();
    wait_col(4'b0100);
    filas = 4'b0010;
    repeat (6) cycle();
    chk("press_not_yet_valid", 32'(key_valid), 32'd0);
    cycle();
    chk("press_valid", 32'(key_valid), 32'd1);
    chk("press_code", 32'(key_code), 32'b1001);
    chk("press_held", 32'(key_held), 32'd1);
    repeat (13) cycle();
    chk("press_frozen", 32'(columnas), 32'b0100);
    key_ack = 1'b1;
    cycle();
    key_ack = 1'b0;
    chk("ack_clears", 32'(key_valid), 32'd0);
    filas = 4'd0;
    repeat (2) cycle();
    chk("release_still_held", 32'(key_held), 32'd1);
    cycle();
    chk("release_done", 32'(key_held), 32'd0);
    chk("release_resume", 32'(columnas), 32'b1000);

    // Bounce during debounce: no key, rescan column 2 from a fresh divider.
    do_reset();
    wait_col(4'b0100);
    filas = 4'b0010;
    repeat (5) cycle();
    filas = 4'd0;
    cycle();
    chk("bounce_col", 32'(columnas), 32'b0100);
    repeat (3) cycle();
    chk("bounce_div0", 32'(columnas), 32'b0100);
    cycle();
    chk("bounce_next_col", 32'(columnas), 32'b1000);
    chk("bounce_no_key", 32'(key_valid), 32'd0);

    // Overrun, then an ack coinciding with a new load.
    do_reset();
    press_release(0, 0);
    chk("first_valid", 32'(key_valid), 32'd1);
    chk("first_code", 32'(key_code), 32'b0000);
    press_release(3, 3);
    chk("ovr_code_kept", 32'(key_code), 32'b0000);
    chk("ovr_valid", 32'(key_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    wait_col(4'b0010);
    filas = 4'b0100;
    repeat (6) cycle();
    key_ack = 1'b1;
    cycle();
    key_ack = 1'b0;
    chk("ack_load_code", 32'(key_code), 32'b0110);
    chk("ack_load_valid", 32'(key_valid), 32'd1);
    cycle();
    chk("ack_load_valid_after", 32'(key_valid), 32'd1);
    chk("ack_load_held", 32'(key_held), 32'd1);

    // Disable while held, then reset.
    enable = 1'b0;
    cycle();
    chk("dis_columnas", 32'(columnas), 32'd0);
    chk("dis_held", 32'(key_held), 32'd0);
    chk("dis_valid", 32'(key_valid), 32'd1);
    chk("dis_code", 32'(key_code), 32'b0110);
    reset = 1'b0;
    cycle();
    chk("rst_columnas", 32'(columnas), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1; enable = 1'b1; filas = 4'd0;

    // Random segments of held row patterns with sporadic ack, disable and reset.
    for (int s = 0; s < 400; s++) begin
      int len;
      int pick;
      len = $urandom_range(1, 14);
      pick = $urandom_range(0, 99);
      if (pick < 60) filas = 4'(1 << $urandom_range(0, 3));
      else if (pick < 85) filas = 4'd0;
      else filas = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 49) != 0);
      for (int k = 0; k < len; k++) begin
        key_ack = ($urandom_range(0, 7) == 0);
        reset = ($urandom_range(0, 299) != 0);
        cycle();
      end
    end
    key_ack = 1'b0; reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequencer for the 4x4 matrix keypad. It drives the column strobes one at a time, samples the row inputs, and debounces both press and release. Each debounced press yields one key code, held under a valid/ack handshake for the calculator FSM. It replaces free-running column drive with a scan that freezes on the pressed column, and it adds overrun reporting.

Parameters:
SCAN_DIV, 1000, clk cycles each column is driven before its rows are sampled (min 2)
DEBOUNCE_CNT, 50000, consecutive stable cycles required to accept a press or a release (min 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
enable  input  1  scan enable; low parks the controller
filas  input  4  row sense lines, active-high, bit i = row i
columnas  output  4  one-hot column drive, bit j = column j; 4'b0000 when idle
key_code  output  4  [3:2] = column index, [1:0] = row index of the accepted key
key_valid  output  1  key_code holds an unconsumed key
key_ack  input  1  consumer accepts key_code; sampled only while key_valid=1
key_held  output  1  a debounced key is currently down
overrun  output  1  sticky: a press was debounced while key_valid was still pending

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, columnas=0, key_code=0, key_valid=0, key_held=0, overrun=0, all counters=0. Reset overrides every other input in that cycle.
- Counters: div counter is $clog2(SCAN_DIV) bits; debounce counter is $clog2(DEBOUNCE_CNT) bits. Column index is 2 bits and wraps 3->0.
- Row sample is valid only when filas is exactly one-hot. Zero or multiple bits set counts as "no key".
- IDLE: columnas=0. If enable=1, go to SCAN with col=0, div=0.
- SCAN:
  - columnas = 1<<col; div increments each cycle.
  - At div==SCAN_DIV-1 with a valid one-hot row: latch col and row, set db=0, go to DEBOUNCE; columnas stays on that column.
  - At div==SCAN_DIV-1 otherwise: col++ (wrap), div=0.
- DEBOUNCE:
  - filas equals the latched one-hot row: db++.
  - When db==DEBOUNCE_CNT-1 and filas still matches: go to PRESSED and attempt a load.
  - Any mismatch: return to SCAN on the same column with div=0; no key is produced.
- Load (on DEBOUNCE->PRESSED):
  - If key_valid=0, or key_ack=1 in the same cycle: key_code={col,row} and key_valid=1 from the next cycle.
  - Otherwise key_code is unchanged and overrun is set to 1.
- PRESSED:
  - key_held=1; columnas stays frozen on the latched column.
  - Release counter counts consecutive cycles with filas != latched row. Any match resets it to 0.
  - At count DEBOUNCE_CNT-1: key_held=0, go to SCAN with col = latched col+1 (wrap) and div=0. There is no auto-repeat.
- Handshake:
  - key_valid=1 and key_ack=1 at an edge: key_valid=0 next cycle, unless a load happens in the same cycle, in which case the load wins and key_valid stays 1.
  - key_ack while key_valid=0 is ignored.
  - key_code is stable while key_valid=1.
- enable=0 in any state: go to IDLE next cycle, columnas=0, key_held=0, counters cleared. key_valid, key_code and overrun are retained, and ack still works. Re-enable restarts at col=0.
- overrun clears only on reset.
- Latency: key_valid rises DEBOUNCE_CNT cycles after DEBOUNCE entry (stable input). Worst-case detection to DEBOUNCE entry is 4*SCAN_DIV cycles.

Test Plan:
(All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3.)
1. Reset released with enable=1 and filas=0: columnas=0000 for 1 cycle, then 0001, 0010, 0100, 1000 for 4 cycles each, then wraps to 0001. key_valid=0 and overrun=0 throughout.
2. filas=0010 whenever columnas=0100, held 20 cycles: scan freezes at 0100, key_valid=1 with key_code=4'b1001 three cycles after DEBOUNCE entry, key_held=1. Pulse key_ack -> key_valid=0 next cycle. Release filas -> key_held=0 after 3 cycles, and scan resumes at 1000.
3. Same press with filas dropped to 0 for 1 cycle during DEBOUNCE: key_valid never rises; scan resumes on column 2 with div=0.
4. filas=0011 on column 0: treated as no key; columnas advances to 0010 normally.
5. Press col0/row0 (not acked), release, then press col3/row3: key_code stays 4'b0000 with key_valid=1, overrun=1. Then ack in the same cycle as a third debounced press col1/row2 -> key_code=4'b0110, key_valid stays 1.
6. enable driven to 0 while in PRESSED with key_valid=1: next cycle columnas=0000 and key_held=0, key_valid=1 and key_code retained. reset=0 for one edge -> all outputs return to their reset values.
